// File: rtl/pwm_frame_scheduler.sv
// Serial 8-channel PWM sequencer: shifts one duty-compare frame per tick, then pulses latch.
// Outputs are registered one cycle after phase; the host write port only stalls during the act<-pend commit cycle.
module pwm_frame_scheduler #(
    parameter int CHANNELS   = 8,
    parameter int CNT_W      = 7,
    parameter int PERIOD_MAX = 99
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        en,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [$clog2(CHANNELS)-1:0] wr_ch,
    input  logic [CNT_W-1:0]            wr_duty,
    output logic                        s_out,
    output logic                        latch,
    output logic                        period_start,
    output logic                        busy
);

    localparam int                PH_W     = $clog2(CHANNELS);
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD_MAX);
    localparam logic [CNT_W-1:0]  DUTY_MAX = CNT_W'(PERIOD_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   pend [CHANNELS];
    logic [CNT_W-1:0]   act  [CHANNELS];
    logic [CNT_W-1:0]   cnt;
    logic [PH_W-1:0]    ph;
    logic [PH_W-1:0]    bit_ch;
    logic [CNT_W-1:0]   duty_clamped;
    logic               ready_en;
    logic               frame_end;
    logic               start;
    logic               commit;
    logic               wr_fire;
    logic               ch_ok;
    logic               s_out_nxt;
    logic               ps_nxt;
    logic               frame_done_q;

    assign frame_end    = (state != ST_IDLE) && (ph == PH_LAST);
    assign start        = (state == ST_IDLE) && en;
    assign commit       = start || ((state == ST_RUN) && (ph == PH_LAST) && (cnt == CNT_LAST));
    assign wr_ready     = ready_en && !commit;
    assign wr_fire      = wr_valid && wr_ready;
    assign duty_clamped = (wr_duty > DUTY_MAX) ? DUTY_MAX : wr_duty;

    generate
        if ((1 << PH_W) == CHANNELS) begin : g_ch_pow2
            assign ch_ok = 1'b1;
        end else begin : g_ch_npow2
            assign ch_ok = (32'(wr_ch) < 32'(CHANNELS));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A stop request only takes effect on the last phase so frames are never truncated.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (en)               state_nxt = ST_RUN;
            ST_RUN:   if (frame_end && !en) state_nxt = ST_FLUSH;
            ST_FLUSH: if (frame_end)        state_nxt = ST_IDLE;
            default:                        state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        s_out_nxt = 1'b0;
        ps_nxt    = 1'b0;
        bit_ch    = PH_LAST - ph;
        if (state == ST_RUN) begin
            s_out_nxt = (cnt < act[bit_ch]);
            ps_nxt    = (ph == '0) && (cnt == '0);
        end
        busy = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_out        <= 1'b0;
            period_start <= 1'b0;
            frame_done_q <= 1'b0;
            latch        <= 1'b0;
            ready_en     <= 1'b0;
        end else begin
            s_out        <= s_out_nxt;
            period_start <= ps_nxt;
            frame_done_q <= frame_end;
            latch        <= frame_done_q;
            ready_en     <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph  <= '0;
            cnt <= '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (ph == PH_LAST) begin
                        ph  <= '0;
                        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    ph  <= (ph == PH_LAST) ? '0 : ph + 1'b1;
                    cnt <= '0;
                end
                default: begin
                    ph  <= '0;
                    cnt <= '0;
                end
            endcase
        end
    end

    // Writes and commits are mutually exclusive because wr_ready drops on commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pend[i] <= '0;
                act[i]  <= '0;
            end
        end else begin
            if (wr_fire && ch_ok) begin
                pend[wr_ch] <= duty_clamped;
            end
            if (commit) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    act[i] <= pend[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_frame_scheduler.sv
// Directed bench for pwm_frame_scheduler: decodes latched frames into per-period channel high counts.
module tb_pwm_frame_scheduler;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       en = 1'b0;
    logic       wr_valid = 1'b0;
    logic [2:0] wr_ch = '0;
    logic [6:0] wr_duty = '0;
    logic       wr_ready;
    logic       s_out;
    logic       latch;
    logic       period_start;
    logic       busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pwm_frame_scheduler #(
        .CHANNELS  (8),
        .CNT_W     (7),
        .PERIOD_MAX(99)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_ch       (wr_ch),
        .wr_duty     (wr_duty),
        .s_out       (s_out),
        .latch       (latch),
        .period_start(period_start),
        .busy        (busy)
    );

    // Downstream shift/latch register model plus per-period statistics.
    int         cyc = 0;
    int         lat_total = 0;
    int         snap_id = 0;
    int         ps_last = 0;
    int         ps_interval = 0;
    bit         win_open = 1'b0;
    logic [7:0] shreg = '0;
    logic [7:0] wh [256];
    int         win_hi [8];
    int         win_frames = 0;
    int         hist_hi [16][8];
    int         hist_frames [16];

    always @(negedge clk) begin
        cyc++;
        if (latch === 1'b1) begin
            wh[lat_total % 256] = shreg;
            lat_total++;
            for (int i = 0; i < 8; i++) if (shreg[i] === 1'b1) win_hi[i]++;
            win_frames++;
        end
        shreg = {shreg[6:0], s_out};
        if (reset_n !== 1'b1 || busy !== 1'b1) begin
            win_open = 1'b0;
        end else if (period_start === 1'b1) begin
            if (win_open && snap_id < 16) begin
                for (int i = 0; i < 8; i++) hist_hi[snap_id][i] = win_hi[i];
                hist_frames[snap_id] = win_frames;
                snap_id++;
            end
            ps_interval = cyc - ps_last;
            ps_last = cyc;
            for (int i = 0; i < 8; i++) win_hi[i] = 0;
            win_frames = 0;
            win_open = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int ch, input int duty);
        int tries = 0;
        wr_valid = 1'b1;
        wr_ch    = 3'(ch);
        wr_duty  = 7'(duty);
        while (wr_ready !== 1'b1 && tries < 20) begin
            tick();
            tries++;
        end
        chk($sformatf("wr_ready_ch%0d", ch), 32'(wr_ready), 1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_snap(input int n);
        int t = 0;
        while (snap_id < n && t < 3000) begin
            tick();
            t++;
        end
        chk($sformatf("snap%0d_reached", n), 32'(snap_id >= n), 1);
    endtask

    task automatic wait_ps();
        int t = 0;
        tick();
        while (period_start !== 1'b1 && t < 1000) begin
            tick();
            t++;
        end
        chk("ps_seen", 32'(period_start), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        int lat_j;
        int ps_j;
        int l0;
        int s0;
        int sum;

        #1 reset_n = 1'b0;
        tick(3);
        chk("rst_s_out", 32'(s_out), 0);
        chk("rst_latch", 32'(latch), 0);
        chk("rst_ps", 32'(period_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        #2 reset_n = 1'b1;
        #1 chk("rdy_before_edge", 32'(wr_ready), 0);
        tick();
        chk("rdy_after_edge", 32'(wr_ready), 1);

        viol = 0;
        repeat (1000) begin
            tick();
            if (s_out !== 1'b0 || latch !== 1'b0 || busy !== 1'b0 ||
                period_start !== 1'b0 || wr_ready !== 1'b1) viol++;
        end
        chk("idle_quiet", viol, 0);

        for (int i = 0; i < 8; i++) wr(i, (i + 1) * 10);

        en = 1'b1;
        #1 chk("rdy_start_commit", 32'(wr_ready), 0);
        lat_j = 0;
        ps_j = 0;
        for (int k = 1; k <= 20 && lat_j == 0; k++) begin
            tick();
            if (k == 1) chk("busy_run", 32'(busy), 1);
            if (period_start === 1'b1 && ps_j == 0) ps_j = k;
            if (latch === 1'b1) lat_j = k;
        end
        chk("first_ps", ps_j, 2);
        chk("first_latch", lat_j, 10);

        wait_snap(1);
        for (int i = 0; i < 8; i++) chk($sformatf("p1_ch%0d", i), hist_hi[0][i], (i + 1) * 10);
        chk("p1_frames", hist_frames[0], 100);
        chk("ps_interval", ps_interval, 800);

        wr(0, 0);
        wr(1, 100);
        wr(2, 127);
        wait_snap(3);
        chk("p2_ch0_old", hist_hi[1][0], 10);
        chk("p2_ch2_old", hist_hi[1][2], 30);
        chk("p3_ch0_zero", hist_hi[2][0], 0);
        chk("p3_ch1_full", hist_hi[2][1], 100);
        chk("p3_ch2_clamp", hist_hi[2][2], 100);
        chk("p3_ch3", hist_hi[2][3], 40);

        tick(400);
        wr(3, 70);
        wr(5, 33);
        wr(5, 45);
        wait_ps();
        tick(798);
        wr_valid = 1'b1;
        wr_ch    = 3'd4;
        wr_duty  = 7'd25;
        #1 chk("rdy_commit_cycle", 32'(wr_ready), 0);
        tick();
        chk("rdy_after_commit", 32'(wr_ready), 1);
        tick();
        wr_valid = 1'b0;

        wait_snap(7);
        chk("p4_ch3_old", hist_hi[3][3], 40);
        chk("p4_ch5_old", hist_hi[3][5], 60);
        chk("p5_ch3_new", hist_hi[4][3], 70);
        chk("p5_ch5_last_wins", hist_hi[4][5], 45);
        chk("p6_ch4_late", hist_hi[5][4], 50);
        chk("p7_ch4_new", hist_hi[6][4], 25);
        chk("p7_frames", hist_frames[6], 100);

        wait_ps();
        tick(3);
        en = 1'b0;
        l0 = lat_total;
        tick(11);
        chk("busy_flush_end", 32'(busy), 1);
        tick();
        chk("busy_fall", 32'(busy), 0);
        tick();
        chk("flush_latch", 32'(latch), 1);
        tick(100);
        chk("stop_latches", lat_total - l0, 2);
        chk("stop_word_last_run", 32'(wh[l0 % 256]), 32'h0000_00FE);
        chk("stop_word_flush", 32'(wh[(l0 + 1) % 256]), 0);

        en = 1'b1;
        wait_ps();
        tick(3);
        chk("pre_rst_s_out", 32'(s_out), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_s_out", 32'(s_out), 0);
        chk("arst_latch", 32'(latch), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ps", 32'(period_start), 0);
        chk("arst_wr_ready", 32'(wr_ready), 0);
        tick(2);
        #2 reset_n = 1'b1;
        s0 = snap_id;
        wait_snap(s0 + 1);
        sum = 0;
        for (int i = 0; i < 8; i++) sum += hist_hi[s0][i];
        chk("restart_all_zero", sum, 0);
        chk("restart_frames", hist_frames[s0], 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
